// File: rtl/mips_pkg.sv
// Shared datapath widths and the write-back request type used across the
// register-file write path.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     wd;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result queue: circular buffer with per-entry live bits that a
// younger ALU write can clear by destination register, plus a pending mask.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int   DEPTH = 4,
  localparam int  PTR_W = $clog2(DEPTH),
  localparam int  CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_req_t               push_req_i,
  input  logic                  push_live_i,
  input  logic                  pop_i,
  input  logic                  kill_en_i,
  input  logic [REG_ADDR_W-1:0] kill_rd_i,
  output wb_req_t               head_req_o,
  output logic                  head_live_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [31:0]           pending_o
);

  wb_req_t              mem_q [DEPTH];
  wb_req_t              mem_d [DEPTH];
  logic [DEPTH-1:0]     live_q, live_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push_ok_s, pop_ok_s;

  assign empty_o     = (count_q == CNT_W'(0));
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign push_ok_s   = push_i && !full_o;
  assign pop_ok_s    = pop_i && !empty_o;
  assign head_req_o  = mem_q[head_q];
  assign head_live_o = live_q[head_q];
  assign count_o     = count_q;

  // Next-state: kill matching entries, retire head, then write the new tail.
  always_comb begin
    mem_d   = mem_q;
    live_d  = live_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en_i && (mem_q[i].rd == kill_rd_i)) begin
        live_d[i] = 1'b0;
      end else begin
        live_d[i] = live_d[i];
      end
    end
    if (pop_ok_s) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    if (push_ok_s) begin
      mem_d[tail_q]  = push_req_i;
      live_d[tail_q] = push_live_i;
      tail_d         = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      live_q  <= live_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entries with rd 0 are never live, so bit 0 stays clear.
  always_comb begin
    pending_o = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) begin
      pending_o[mem_q[i].rd] = pending_o[mem_q[i].rd] | live_q[i];
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: the ALU path always wins, long-latency
// results drain from a queue, and stale queued results are suppressed.
module wb_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_we,
  input  logic [REG_ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]            alu_wd,
  input  logic                         ll_valid,
  output logic                         ll_ready,
  input  logic [REG_ADDR_W-1:0]        ll_rd,
  input  logic [DATA_W-1:0]            ll_wd,
  output logic                         WE3,
  output logic [REG_ADDR_W-1:0]        a3,
  output logic [DATA_W-1:0]            WD3,
  output logic [31:0]                  pending,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  logic                  alu_issue_s;
  logic                  push_s, pop_s, push_live_s;
  logic                  empty_s, full_s, head_live_s;
  wb_req_t               push_req_s, head_req_s;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0]     wd_q, wd_d;

  assign alu_issue_s = alu_we && (alu_rd != REG_ADDR_W'(0));
  assign ll_ready    = !full_s;
  assign push_s      = ll_valid && ll_ready;
  // A same-cycle ALU write to the same register is younger and wins.
  assign push_live_s = (ll_rd != REG_ADDR_W'(0)) && !(alu_we && (alu_rd == ll_rd));
  assign push_req_s  = '{rd: ll_rd, wd: ll_wd};
  assign pop_s       = !alu_issue_s && !empty_s;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_req_i  (push_req_s),
    .push_live_i (push_live_s),
    .pop_i       (pop_s),
    .kill_en_i   (alu_issue_s),
    .kill_rd_i   (alu_rd),
    .head_req_o  (head_req_s),
    .head_live_o (head_live_s),
    .empty_o     (empty_s),
    .full_o      (full_s),
    .count_o     (count),
    .pending_o   (pending)
  );

  // Issue select feeding the write-port registers.
  always_comb begin
    we_d = 1'b0;
    a3_d = '0;
    wd_d = '0;
    if (alu_issue_s) begin
      we_d = 1'b1;
      a3_d = alu_rd;
      wd_d = alu_wd;
    end else if (pop_s && head_live_s) begin
      we_d = 1'b1;
      a3_d = head_req_s.rd;
      wd_d = head_req_s.wd;
    end else begin
      we_d = 1'b0;
      a3_d = '0;
      wd_d = '0;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q <= 1'b0;
      a3_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      a3_q <= a3_d;
      wd_q <= wd_d;
    end
  end

  assign WE3 = we_q;
  assign a3  = a3_q;
  assign WD3 = wd_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: hand-computed expectations for ALU
// priority, queue drain order, kill-by-rd, rd 0 suppression and async reset.
module tb_wb_write_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_wd;
  logic        WE3;
  logic [4:0]  a3;
  logic [31:0] WD3;
  logic [31:0] pending;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  wb_write_arbiter #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_we   (alu_we),
    .alu_rd   (alu_rd),
    .alu_wd   (alu_wd),
    .ll_valid (ll_valid),
    .ll_ready (ll_ready),
    .ll_rd    (ll_rd),
    .ll_wd    (ll_wd),
    .WE3      (WE3),
    .a3       (a3),
    .WD3      (WD3),
    .pending  (pending),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_we   = 1'b0;
    alu_rd   = 5'd0;
    alu_wd   = 32'h0;
    ll_valid = 1'b0;
    ll_rd    = 5'd0;
    ll_wd    = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #3;
    chk("rst_we",      {31'b0, WE3},      32'h0);
    chk("rst_a3",      {27'b0, a3},       32'h0);
    chk("rst_wd",      WD3,               32'h0);
    chk("rst_count",   {29'b0, count},    32'h0);
    chk("rst_pending", pending,           32'h0);
    chk("rst_ready",   {31'b0, ll_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Single ALU write appears one edge later, then drops.
    alu_we = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEAD_BEEF;
    cyc();
    chk("alu_we",  {31'b0, WE3}, 32'h1);
    chk("alu_a3",  {27'b0, a3},  32'h5);
    chk("alu_wd",  WD3,          32'hDEAD_BEEF);
    idle_inputs();
    cyc();
    chk("alu_we_off", {31'b0, WE3}, 32'h0);

    // Fill the queue while the ALU hogs the port, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      alu_we = 1'b1; alu_rd = 5'd9; alu_wd = 32'h99;
      ll_valid = 1'b1; ll_rd = 5'(i); ll_wd = 32'(i * 16);
      cyc();
    end
    ll_valid = 1'b0;
    chk("full_count",   {29'b0, count},    32'h4);
    chk("full_ready",   {31'b0, ll_ready}, 32'h0);
    chk("full_pending", pending,           32'h0000_001E);
    chk("full_alu_a3",  {27'b0, a3},       32'h9);
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("drain_we", {31'b0, WE3}, 32'h1);
      chk("drain_a3", {27'b0, a3},  32'(i));
      chk("drain_wd", WD3,          32'(i * 16));
    end
    chk("drain_count",   {29'b0, count}, 32'h0);
    chk("drain_pending", pending,        32'h0);
    cyc();
    chk("drain_idle", {31'b0, WE3}, 32'h0);

    // Younger ALU write kills an older queued result to the same register.
    ll_valid = 1'b1; ll_rd = 5'd7; ll_wd = 32'h1;
    cyc();
    chk("kill_pend_set", pending,        32'h0000_0080);
    chk("kill_cnt1",     {29'b0, count}, 32'h1);
    ll_valid = 1'b0;
    alu_we = 1'b1; alu_rd = 5'd7; alu_wd = 32'h2;
    cyc();
    chk("kill_alu_we", {31'b0, WE3}, 32'h1);
    chk("kill_alu_a3", {27'b0, a3},  32'h7);
    chk("kill_alu_wd", WD3,          32'h2);
    chk("kill_pend",   pending,      32'h0);
    idle_inputs();
    cyc();
    chk("kill_pop_we", {31'b0, WE3},    32'h0);
    chk("kill_cnt0",   {29'b0, count},  32'h0);

    // Same-cycle push and ALU write to the same register.
    alu_we = 1'b1; alu_rd = 5'd3; alu_wd = 32'h44;
    ll_valid = 1'b1; ll_rd = 5'd3; ll_wd = 32'h33;
    cyc();
    chk("same_wd",   WD3,            32'h44);
    chk("same_cnt",  {29'b0, count}, 32'h1);
    chk("same_pend", pending,        32'h0);
    idle_inputs();
    cyc();
    chk("same_pop_we", {31'b0, WE3},   32'h0);
    chk("same_cnt0",   {29'b0, count}, 32'h0);

    // Register 0 is never written from either path.
    alu_we = 1'b1; alu_rd = 5'd0; alu_wd = 32'h66;
    ll_valid = 1'b1; ll_rd = 5'd0; ll_wd = 32'h55;
    cyc();
    chk("r0_we",  {31'b0, WE3},   32'h0);
    chk("r0_cnt", {29'b0, count}, 32'h1);
    idle_inputs();
    cyc();
    chk("r0_pop_we", {31'b0, WE3},   32'h0);
    chk("r0_cnt0",   {29'b0, count}, 32'h0);

    // Asynchronous reset with three entries queued.
    for (int i = 10; i <= 12; i++) begin
      alu_we = 1'b1; alu_rd = 5'd9; alu_wd = 32'h99;
      ll_valid = 1'b1; ll_rd = 5'(i); ll_wd = 32'(i);
      cyc();
    end
    chk("pre_rst_cnt", {29'b0, count}, 32'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we",    {31'b0, WE3},      32'h0);
    chk("arst_cnt",   {29'b0, count},    32'h0);
    chk("arst_pend",  pending,           32'h0);
    chk("arst_ready", {31'b0, ll_ready}, 32'h1);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_we",  {31'b0, WE3},   32'h0);
      chk("post_rst_cnt", {29'b0, count}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
